// File: rtl/fc_sequencer_pkg.sv
// Shared constants and FSM encoding for the fully-connected layer sequencer.
// Module parameters default to these values.
package fc_sequencer_pkg;

  localparam int N_IN = 9;
  localparam int DW   = 8;
  localparam int ACCW = 32;
  localparam int MAXN = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_BIAS,
    S_OUT,
    S_FIN
  } fc_state_t;

endpackage

// File: rtl/fc_mac.sv
// Signed multiply-accumulate: acc += sext(a) * sext(b), wrapping modulo 2^ACCW.
// clear wins over en so a new neuron always starts from zero.
module fc_mac import fc_sequencer_pkg::*; #(
  parameter int DW   = fc_sequencer_pkg::DW,
  parameter int ACCW = fc_sequencer_pkg::ACCW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            en,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [ACCW-1:0] acc
);

  logic signed [2*DW-1:0] prod;

  assign prod = $signed(a) * $signed(b);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
    end
  end

endmodule

// File: rtl/fc_sequencer.sv
// Sequences one fully-connected layer: per neuron, streams N_IN weights from a
// 1-cycle-latency ROM through fc_mac, adds the bias, then offers the result.
module fc_sequencer import fc_sequencer_pkg::*; #(
  parameter int N_IN = fc_sequencer_pkg::N_IN,
  parameter int DW   = fc_sequencer_pkg::DW,
  parameter int ACCW = fc_sequencer_pkg::ACCW,
  parameter int MAXN = fc_sequencer_pkg::MAXN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4:0]           num_neurons,
  input  logic [N_IN*DW-1:0]   fc_input,
  output logic [7:0]           w_addr,
  input  logic [DW-1:0]        w_data,
  output logic [3:0]           b_addr,
  input  logic [DW-1:0]        b_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACCW-1:0]      out_data,
  output logic [3:0]           out_idx,
  output logic                 busy,
  output logic                 done,
  output fc_state_t            dbg_state
);

  localparam int CW = $clog2(N_IN + 1);

  fc_state_t           state;
  logic [N_IN*DW-1:0]  feat_q;
  logic [4:0]          num_q;
  logic [4:0]          num_clamped;
  logic [3:0]          neuron;
  logic [CW-1:0]       mac_cnt;
  logic [DW-1:0]       feat_sel;
  logic [ACCW-1:0]     acc;
  logic                accept;
  logic                handshake;
  logic                last_neuron;
  logic                mac_clear;
  logic                mac_en;

  // Output handshake: a result transfers on a rising edge where out_valid and
  // out_ready are both high; until then out_valid/out_data/out_idx hold and
  // out_valid never drops without a transfer (except on rst).
  assign handshake   = (state == S_OUT) && out_valid && out_ready;
  assign accept      = (state == S_IDLE) && start && !busy;
  assign num_clamped = (num_neurons > 5'(MAXN)) ? 5'(MAXN) : num_neurons;
  assign last_neuron = ({1'b0, neuron} + 5'd1) >= num_q;
  assign dbg_state   = state;

  // mac_cnt==0 is the cycle whose address is on the bus but no data is back
  // yet; counts 1..N_IN each carry the weight for feature mac_cnt-1.
  assign mac_clear = (accept && (num_clamped != 5'd0)) || (handshake && !last_neuron);
  assign mac_en    = (state == S_MAC) && (mac_cnt != '0);

  always_comb begin
    feat_sel = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (mac_cnt == CW'(k + 1)) feat_sel = feat_q[k*DW +: DW];
    end
  end

  fc_mac #(
    .DW   (DW),
    .ACCW (ACCW)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clear (mac_clear),
    .en    (mac_en),
    .a     (w_data),
    .b     (feat_sel),
    .acc   (acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      mac_cnt   <= '0;
      neuron    <= '0;
      num_q     <= '0;
      feat_q    <= '0;
      w_addr    <= '0;
      b_addr    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          busy <= accept;
          if (accept) begin
            feat_q  <= fc_input;
            num_q   <= num_clamped;
            neuron  <= '0;
            mac_cnt <= '0;
            w_addr  <= '0;
            b_addr  <= '0;
            state   <= (num_clamped == 5'd0) ? S_FIN : S_MAC;
          end
        end
        S_MAC: begin
          w_addr <= w_addr + 8'd1;
          if (mac_cnt == CW'(N_IN)) begin
            state <= S_BIAS;
          end else begin
            mac_cnt <= mac_cnt + CW'(1);
          end
        end
        S_BIAS: begin
          out_data  <= acc + {{(ACCW-DW){b_data[DW-1]}}, b_data};
          out_idx   <= neuron;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (handshake) begin
            out_valid <= 1'b0;
            if (last_neuron) begin
              state <= S_FIN;
            end else begin
              neuron  <= neuron + 4'd1;
              mac_cnt <= '0;
              w_addr  <= 8'((int'(neuron) + 1) * N_IN);
              b_addr  <= neuron + 4'd1;
              state   <= S_MAC;
            end
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_sequencer.sv
// Bench for fc_sequencer: ROM models, a transaction-level reference model,
// a per-cycle compare process, directed scenarios and randomized runs.
`timescale 1ns/1ps
module tb_fc_sequencer;
  import fc_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                 start;
  logic [4:0]           num_neurons;
  logic [N_IN*DW-1:0]   fc_input;
  logic [7:0]           w_addr;
  logic [DW-1:0]        w_data;
  logic [3:0]           b_addr;
  logic [DW-1:0]        b_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACCW-1:0]      out_data;
  logic [3:0]           out_idx;
  logic                 busy;
  logic                 done;
  fc_state_t            dbg_state;

  fc_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_neurons (num_neurons),
    .fc_input    (fc_input),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .b_addr      (b_addr),
    .b_data      (b_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_idx     (out_idx),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  // ---------------- ROM models (1-cycle read latency) ----------------
  byte wrom [256];
  byte brom [16];
  always @(posedge clk) begin
    w_data <= wrom[w_addr];
    b_data <= brom[b_addr];
  end

  // ---------------- counters / check ----------------
  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, $signed(act), $signed(exp), $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Results are computed whole at start from the ROM contents and latched
  // features; timing follows the externally visible rules: first result 11
  // edges after start, next 11 edges after each transfer, done one edge after
  // the last transfer (or after a zero-neuron start), busy drops with done.
  logic [31:0] exp_q[$];
  bit          m_valid, m_busy, m_done, m_dpend;
  logic [31:0] m_data;
  logic [3:0]  m_idx, m_next;
  int          m_cd;

  always @(posedge clk) begin
    bit hs, old_busy;
    int n, s;
    hs       = m_valid && out_ready;
    old_busy = m_busy;
    if (rst) begin
      m_valid = 0; m_busy = 0; m_done = 0; m_dpend = 0;
      m_data = '0; m_idx = '0; m_next = '0; m_cd = 0;
      exp_q.delete();
    end else begin
      if (m_done) begin
        m_done = 0;
        m_busy = 0;
      end else if (m_dpend) begin
        m_done  = 1;
        m_dpend = 0;
      end
      if (m_cd > 0) begin
        m_cd--;
        if (m_cd == 0) begin
          m_valid = 1;
          m_data  = exp_q.pop_front();
          m_idx   = m_next;
          m_next  = m_next + 4'd1;
        end
      end
      if (hs) begin
        m_valid = 0;
        if (exp_q.size() == 0) m_dpend = 1;
        else m_cd = 11;
      end
      if (!old_busy && start) begin
        n = (num_neurons > MAXN) ? MAXN : int'(num_neurons);
        for (int j = 0; j < n; j++) begin
          s = int'(brom[j]);
          for (int k = 0; k < N_IN; k++)
            s += int'(wrom[j*N_IN+k]) * int'($signed(fc_input[k*DW +: DW]));
          exp_q.push_back(s);
        end
        m_busy = 1;
        m_next = '0;
        if (n == 0) m_dpend = 1;
        else m_cd = 11;
      end
    end
  end

  // ---------------- compare process / monitor ----------------
  logic [31:0] got_q[$];
  logic [3:0]  got_idx[$];
  bit          prev_valid = 0;
  logic [7:0]  hold_waddr;
  int          t_vrise, t_done, done_cnt;

  always @(negedge clk) begin
    check("out_valid", out_valid, m_valid);
    check("busy", busy, m_busy);
    check("done", done, m_done);
    if (m_valid) begin
      check("out_data", out_data, m_data);
      check("out_idx", 32'(out_idx), 32'(m_idx));
    end
    // while a result waits, the weight address bus must not advance
    if (out_valid && prev_valid) check("w_addr_stall", 32'(w_addr), 32'(hold_waddr));
    if (out_valid && !prev_valid) begin
      hold_waddr = w_addr;
      if (t_vrise < 0) t_vrise = cyc;
    end
    if (done) begin
      done_cnt++;
      if (t_done < 0) t_done = cyc;
    end
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
      got_idx.push_back(out_idx);
    end
    prev_valid = out_valid;
  end

  // ---------------- ready driver ----------------
  int ready_mode  = 0;   // 0: always ready, 1: random, 2: follow ready_force
  bit ready_force = 1;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = ready_force;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  int e0;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    tick(n);
    rst = 1'b0;
  endtask

  function automatic logic [N_IN*DW-1:0] rep(input logic [7:0] v);
    logic [N_IN*DW-1:0] r;
    for (int k = 0; k < N_IN; k++) r[k*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [31:0] got_at(input int i);
    return (got_q.size() > i) ? got_q[i] : 32'hdead_beef;
  endfunction

  task automatic fill_rom(input int mode, input byte wv, input byte bv);
    for (int a = 0; a < 256; a++)
      wrom[a] = (mode == 0) ? wv : (mode == 1) ? byte'(a / N_IN + 1) : byte'($urandom);
    for (int b = 0; b < 16; b++)
      brom[b] = (mode == 2) ? byte'($urandom) : bv;
  endtask

  // start pulse for one cycle; features are scrambled right after the latch
  task automatic start_run(input logic [4:0] num, input logic [N_IN*DW-1:0] feats);
    got_q.delete();
    got_idx.delete();
    t_vrise  = -1;
    t_done   = -1;
    done_cnt = 0;
    num_neurons = num;
    fc_input    = feats;
    start       = 1'b1;
    e0          = cyc + 1;
    tick(1);
    start       = 1'b0;
    fc_input    = {$urandom, $urandom, $urandom};
    num_neurons = 5'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_seen", done, 1'b1);
    tick(3);
  endtask

  task automatic wait_valid(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("valid_seen", out_valid, 1'b1);
    tick(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    start = 1'b0;
    num_neurons = '0;
    fc_input = '0;
    fill_rom(0, 8'sd0, 8'sd0);
    do_reset(4);

    // reset state
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_w_addr", 32'(w_addr), 32'd0);
    check("rst_b_addr", 32'(b_addr), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));

    // single neuron: 9*1*2 + 5
    ready_mode = 0;
    fill_rom(0, 8'sd2, 8'sd5);
    start_run(5'd1, rep(8'd1));
    wait_done(200);
    check("s1_data", got_at(0), 32'd23);
    check("s1_valid_time", 32'(t_vrise), 32'(e0 + 11));
    check("s1_done_time", 32'(t_done), 32'(e0 + 13));

    // three neurons, weight = neuron+1
    fill_rom(1, 8'sd0, 8'sd0);
    start_run(5'd3, rep(8'd1));
    wait_done(300);
    check("s2_count", 32'(got_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("s2_data", got_at(i), 32'(9 * (i + 1)));
      if (got_idx.size() > i) check("s2_idx", 32'(got_idx[i]), 32'(i));
    end

    // stall in OUT for 5 cycles
    ready_mode  = 2;
    ready_force = 1'b0;
    tick(2);
    start_run(5'd2, rep(8'd1));
    wait_valid(100);
    tick(5);
    check("stall_hold", out_data, 32'd9);
    ready_force = 1'b1;
    wait_done(300);
    check("stall_r0", got_at(0), 32'd9);
    check("stall_r1", got_at(1), 32'd18);
    ready_mode = 0;

    // zero neurons
    start_run(5'd0, rep(8'd1));
    tick(5);
    check("zero_done_time", 32'(t_done), 32'(e0 + 1));
    check("zero_done_cnt", 32'(done_cnt), 32'd1);
    check("zero_no_valid", 32'(t_vrise), 32'hffff_ffff);

    // reset during MAC of neuron 1, then rerun
    start_run(5'd3, rep(8'd1));
    for (int i = 0; i < 100 && got_q.size() < 1; i++) tick(1);
    tick(4);
    do_reset(1);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_state", 32'(dbg_state), 32'(S_IDLE));
    tick(2);
    start_run(5'd3, rep(8'd1));
    wait_done(300);
    for (int i = 0; i < 3; i++) check("rerun_data", got_at(i), 32'(9 * (i + 1)));

    // extremes
    fill_rom(0, 8'sd127, 8'sd127);
    start_run(5'd1, rep(8'd127));
    wait_done(200);
    check("max_data", got_at(0), 32'd145288);

    // negative features, start while busy is ignored
    fill_rom(0, 8'sd127, 8'sd0);
    start_run(5'd1, rep(8'h80));
    tick(5);
    start = 1'b1; num_neurons = 5'd5;
    tick(1);
    start = 1'b0;
    wait_done(200);
    check("neg_data", got_at(0), 32'hfffd_c480);
    check("busy_start_count", 32'(got_q.size()), 32'd1);
    check("busy_start_done", 32'(done_cnt), 32'd1);

    // clamp above MAXN
    fill_rom(2, 8'sd0, 8'sd0);
    start_run(5'd20, {$urandom, $urandom, $urandom});
    wait_done(600);
    check("clamp_count", 32'(got_q.size()), 32'(MAXN));

    // randomized runs with random back-pressure
    for (int r = 0; r < 20; r++) begin
      fill_rom(2, 8'sd0, 8'sd0);
      ready_mode = $urandom_range(0, 1);
      n = $urandom_range(0, 18);
      start_run(5'(n), {$urandom, $urandom, $urandom});
      wait_done(1500);
      check("rand_count", 32'(got_q.size()), 32'((n > MAXN) ? MAXN : n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fc_sequencer.md
FC_SEQUENCER -- requirements
Module: fc_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- N_IN, 9, input features per neuron
- DW, 8, signed feature/weight/bias width
- ACCW, 32, signed accumulator and output width
- MAXN, 16, maximum neurons per run
REQ-002 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  run request; sampled only in IDLE.
REQ-005 num_neurons  input  5  neuron count for the run, 0..MAXN; latched on start.
REQ-006 fc_input  input  N_IN*DW  signed features, element k at bits [k*DW +: DW]; latched on start.
REQ-007 w_addr  output  8  weight ROM address, equal to neuron*N_IN+k; ROM read latency 1 cycle.
REQ-008 w_data  input  DW  signed weight returned by the ROM.
REQ-009 b_addr  output  4  bias ROM address, equal to the neuron index; read latency 1 cycle.
REQ-010 b_data  input  DW  signed bias.
REQ-011 out_valid  output  1  out_data holds a finished neuron result.
REQ-012 out_ready  input  1  consumer accepts out_data.
REQ-013 out_data  output  ACCW  signed neuron result.
REQ-014 out_idx  output  4  neuron index of out_data.
REQ-015 busy  output  1  high from the start-accept edge to the done edge.
REQ-016 done  output  1  one-cycle pulse when a run completes.

Function
REQ-017 States: IDLE, MAC, BIAS, OUT, FIN.
- IDLE->MAC on start with num_neurons>0.
- IDLE->FIN on start with num_neurons==0.
- MAC->BIAS after N_IN addresses issued plus 1 drain cycle.
- BIAS->OUT.
- OUT->MAC on handshake when neurons remain; OUT->FIN on handshake for the last neuron.
- FIN->IDLE.
REQ-018 Each MAC cycle with returned data SHALL add sign-extended w_data times the latched feature k to the accumulator; the accumulator SHALL clear on entry to MAC.
REQ-019 Arithmetic SHALL be two's complement modulo 2^ACCW, with wrap and no saturation.
REQ-020 BIAS SHALL register out_data = acc + sign-extended b_data.
REQ-021 Timing:
- With start sampled at edge E0, out_valid SHALL rise at edge E11.
- After each handshake edge H, the next out_valid SHALL rise at H+11.
REQ-022 out_valid, out_data and out_idx SHALL hold stable until the handshake (out_valid && out_ready); no MAC progress SHALL occur while stalled.
REQ-023 out_valid SHALL drop at the handshake edge.
REQ-024 done SHALL pulse in FIN, one cycle after the final handshake or one cycle after a start with num_neurons==0; busy SHALL fall together with done.
REQ-025 start while busy SHALL be ignored.
REQ-026 fc_input changes after latch SHALL NOT affect the run.
REQ-027 num_neurons>MAXN SHALL be clamped to MAXN.
REQ-028 w_addr and b_addr SHALL be registered outputs; their value outside MAC is don't-care.

Reset
REQ-029 rst SHALL force, at the next edge, regardless of state (including mid-MAC or a stalled OUT):
- state=IDLE
- out_valid=0, done=0, busy=0
- out_data=0, out_idx=0
- accumulator=0, counters=0, w_addr=0, b_addr=0
REQ-030 A result pending at reset SHALL be discarded.

Structure
REQ-031 A shared package SHALL hold N_IN, DW, ACCW, MAXN and the state enumeration.
REQ-032 The multiply-accumulate SHALL be a sub-module fc_mac (clear, enable, operands, accumulator out); sequencing SHALL stay in fc_sequencer.

Verification
REQ-033 Directed scenarios:
- Features all 1, weights all 2, bias 5, 1 neuron, out_ready=1 -> out_data=23, out_valid at E11, done at E13.
- 3 neurons, ROM weight = neuron+1, features all 1, bias 0, out_ready=1 -> outputs 9, 18, 27 with idx 0, 1, 2.
- out_ready low for 5 cycles in OUT -> out_data held, no new w_addr, result unchanged after release.
- num_neurons=0 -> no out_valid, done pulses once, one cycle after start.
- rst mid-MAC of neuron 1 -> out_valid=0, busy=0; a fresh start then reproduces the scenario 2 outputs.
- Features 127, weights 127, bias 127 -> out_data=145288; features -128, weights 127 -> accumulator wraps correctly; start while busy -> ignored.
